// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the fetch-buffer entry type used by the IF stage.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; head is read combinationally from storage.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
  endfunction

  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem_q[rd_q];
  assign count     = cnt_q;
  assign empty     = (cnt_q == {CW{1'b0}});
  assign full      = (cnt_q == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_q  <= {AW{1'b0}};
      rd_q  <= {AW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else if (clear) begin
      wr_q  <= {AW{1'b0}};
      rd_q  <= {AW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_q <= ptr_inc(rd_q);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: credit-limited imem requests, PC/response pairing,
// stall back-pressure and redirect flush with stale-response dropping.
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]  pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          run_q;

  logic          credit_ok;
  logic          req_s;
  logic          fire;
  logic          accept;
  logic          buf_pop;
  logic [31:0]   pend_head;
  logic          pend_empty, pend_full;
  logic [CW-1:0] pend_cnt_unused;
  fetch_entry_t  buf_in, buf_head;
  logic [CW-1:0] buf_count;
  logic          buf_empty, buf_full;
  logic [1:0]    rpc_lsb_unused;

  assign rpc_lsb_unused = redirect_pc[1:0];

  // run_q keeps the request line low until the first clock after reset.
  assign credit_ok = ({1'b0, outst_q} + {1'b0, buf_count}) < (CW + 1)'(DEPTH);
  assign req_s     = run_q & credit_ok & ~redirect_valid;
  assign fire      = req_s & imem_gnt;
  assign accept    = imem_rvalid & (drop_q == {CW{1'b0}}) & ~redirect_valid & ~pend_empty & ~buf_full;
  assign buf_pop   = ~buf_empty & ~stall & ~redirect_valid;
  assign buf_in    = '{pc: pend_head, instr: imem_rdata};

  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pend_q (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (fire & ~pend_full),
    .push_data (pc_q),
    .pop       (accept),
    .head_data (pend_head),
    .count     (pend_cnt_unused),
    .empty     (pend_empty),
    .full      (pend_full)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (accept),
    .push_data (buf_in),
    .pop       (buf_pop),
    .head_data (buf_head),
    .count     (buf_count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  // Next PC, in-flight count and stale-response count.
  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q + CW'(fire) - CW'(imem_rvalid);
    drop_d  = drop_q;
    if (redirect_valid) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      drop_d = outst_q - CW'(imem_rvalid);
    end else begin
      if (fire) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      if (imem_rvalid && (drop_q != {CW{1'b0}})) begin
        drop_d = drop_q - CW'(1);
      end else begin
        drop_d = drop_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      outst_q <= {CW{1'b0}};
      drop_q  <= {CW{1'b0}};
      run_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      run_q   <= 1'b1;
    end
  end

  assign imem_req  = req_s;
  assign imem_addr = pc_q;
  assign valid_out = ~buf_empty;
  assign pc_out    = buf_empty ? 32'h0000_0000 : buf_head.pc;
  assign instr_out = buf_empty ? NOP_INSTR : buf_head.instr;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomised/directed bench for if_fetch_stage against a queue-based fetch model.
module tb_if_fetch_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;

  if_fetch_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .pc_out         (pc_out),
    .instr_out      (instr_out),
    .valid_out      (valid_out)
  );

  always #5 clk = ~clk;

  // Requests in flight to memory (stale = issued before a redirect) and presented entries.
  typedef struct { logic [31:0] addr; bit stale; int due; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  infl_t       infl[$];
  ent_t        bq[$];
  logic [31:0] m_pc;
  bit          m_run;
  int          cyc;
  int          checks;
  int          errors;
  int          last_due;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs(input bit exp_req);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("valid_out", 32'(valid_out), 32'(bq.size() > 0));
    chk("pc_out", pc_out, (bq.size() > 0) ? bq[0].pc : 32'h0);
    chk("instr_out", instr_out, (bq.size() > 0) ? bq[0].instr : NOP);
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit g, input int lat_max);
    bit    rv;
    bit    exp_req;
    bit    fire;
    infl_t e;
    int    due;
    @(negedge clk);
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_gnt       = g;
    rv             = (infl.size() > 0) && (infl[0].due <= cyc);
    imem_rvalid    = rv;
    imem_rdata     = rv ? instr_of(infl[0].addr) : $urandom;
    #1;
    exp_req = m_run && ((infl.size() + bq.size()) < DEPTH) && !rd;
    check_outputs(exp_req);
    fire = exp_req && g;
    if (rv) e = infl.pop_front();
    if (rd) begin
      bq.delete();
      for (int i = 0; i < infl.size(); i++) infl[i].stale = 1'b1;
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (bq.size() > 0 && !st) void'(bq.pop_front());
      if (rv && !e.stale) bq.push_back('{pc: e.addr, instr: instr_of(e.addr)});
      if (fire) begin
        due = cyc + $urandom_range(lat_max, 1);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        infl.push_back('{addr: m_pc, stale: 1'b0, due: due});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  // Asynchronous reset mid-cycle, then release on a falling edge.
  task automatic reset_pulse();
    @(negedge clk);
    #2;
    rst            = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    #1;
    infl.delete();
    bq.delete();
    m_pc     = RPC;
    m_run    = 1'b0;
    last_due = cyc;
    check_outputs(1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs(1'b0);
    m_run = 1'b1;
    cyc++;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    last_due = 0;
    m_pc     = RPC;
    m_run    = 1'b0;
    reset_pulse();
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    repeat (5)  step(1'b1, 1'b0, 32'h0, 1'b1, 1);
    repeat (4)  step(1'b0, 1'b0, 32'h0, 1'b1, 2);
    repeat (2)  step(1'b0, 1'b0, 32'h0, 1'b1, 3);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1, 3);
    repeat (8)  step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    step(1'b0, 1'b1, 32'h0000_0203, 1'b1, 1);
    repeat (4)  step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    step(1'b1, 1'b1, 32'h0000_0040, 1'b1, 1);
    repeat (3)  step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    repeat (4)  step(1'b0, 1'b0, 32'h0, 1'b0, 1);
    step(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b1, 1);
    repeat (8)  step(1'b0, 1'b0, 32'h0, 1'b1, 1);
    repeat (400) step($urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0,
                      $urandom, $urandom_range(1, 0) == 1, 4);
    reset_pulse();
    repeat (40) step($urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0,
                     $urandom, $urandom_range(1, 0) == 1, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
